// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES inverse cipher, one round per clock, external key schedule
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] q
);
    localparam logic [2047:0] T = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign q = T[{~a, 3'b000} +: 8];
endmodule

module aes_inv_cipher_iter #(
    parameter int NR = 10,
    parameter int RKI_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [RKI_W-1:0] rk_idx,
    input  logic [127:0]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data
);
    localparam logic [1:0] IDLE = 2'd0, ROUND = 2'd1, LAST = 2'd2, DONE = 2'd3;
    if (!(NR == 10 || NR == 12 || NR == 14) || (2 ** RKI_W) <= NR) begin : g_bad_param
        $error("aes_inv_cipher_iter: illegal NR/RKI_W combination");
    end
    logic [1:0]       fsm;
    logic [RKI_W-1:0] cnt;
    logic [127:0]     st, sr, sb, ark, imc;
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
    endfunction
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_byte
            assign sr[127-8*(r+4*c) -: 8] = st[127-8*(r+4*((c+4-r)%4)) -: 8];
            aes_inv_sbox u_sbox (.a(sr[127-8*(r+4*c) -: 8]), .q(sb[127-8*(r+4*c) -: 8]));
        end
        logic [31:0] w;
        assign w = ark[127-32*c -: 32];
        assign imc[127-32*c -: 32] = {
            gm(w[31:24], 4'he) ^ gm(w[23:16], 4'hb) ^ gm(w[15:8], 4'hd) ^ gm(w[7:0], 4'h9),
            gm(w[31:24], 4'h9) ^ gm(w[23:16], 4'he) ^ gm(w[15:8], 4'hb) ^ gm(w[7:0], 4'hd),
            gm(w[31:24], 4'hd) ^ gm(w[23:16], 4'h9) ^ gm(w[15:8], 4'he) ^ gm(w[7:0], 4'hb),
            gm(w[31:24], 4'hb) ^ gm(w[23:16], 4'hd) ^ gm(w[15:8], 4'h9) ^ gm(w[7:0], 4'he)
        };
    end
    assign ark = sb ^ rk_data;
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm <= IDLE;
            cnt <= '0;
            st  <= '0;
        end else begin
            unique case (fsm)
                IDLE: if (in_valid) begin
                    st  <= in_data ^ rk_data;
                    cnt <= RKI_W'(NR - 1);
                    fsm <= ROUND;
                end
                ROUND: begin
                    st  <= imc;
                    cnt <= cnt - 1'b1;
                    fsm <= cnt == RKI_W'(1) ? LAST : ROUND;
                end
                LAST: begin
                    st  <= ark;
                    fsm <= DONE;
                end
                DONE: if (out_ready) fsm <= IDLE;
            endcase
        end
    end
    assign in_ready  = fsm == IDLE;
    assign out_valid = fsm == DONE;
    assign out_data  = st;
    assign rk_idx    = fsm == IDLE ? RKI_W'(NR) : fsm == ROUND ? cnt : '0;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: directed bench for NR=10 and NR=14 instances with a plaintext scoreboard
module tb_aes_inv_cipher_iter;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;
    logic clk = 1'b0;
    logic rst, iv10, iv14, ordy, ir10, ir14, ov10, ov14;
    logic [3:0] ri10, ri14;
    logic [127:0] din, rd10, rd14, od10, od14;
    logic [127:0] rk10 [0:15];
    logic [127:0] rk14 [0:15];
    logic [7:0] sbox [0:255];
    logic [31:0] w [0:63];
    logic [127:0] sbq [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign rd10 = rk10[ri10];
    assign rd14 = rk14[ri14];

    aes_inv_cipher_iter #(.NR(10), .RKI_W(4)) u10 (
        .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10), .in_data(din),
        .rk_idx(ri10), .rk_data(rd10), .out_valid(ov10), .out_ready(ordy), .out_data(od10)
    );
    aes_inv_cipher_iter #(.NR(14), .RKI_W(4)) u14 (
        .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14), .in_data(din),
        .rk_idx(ri14), .rk_data(rd14), .out_valid(ov14), .out_ready(ordy), .out_data(od14)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction
    function automatic void keyexp(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
    endfunction

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic accept(input int nr, input logic [127:0] ct, input bit push, input string tag);
        din = ct;
        if (nr == 10) iv10 = 1'b1; else iv14 = 1'b1;
        chk({tag, "_in_ready"}, nr == 10 ? ir10 : ir14, 1);
        chk({tag, "_rk_idx_idle"}, nr == 10 ? ri10 : ri14, nr);
        if (push) sbq.push_back(PT);
        step();
        iv10 = 1'b0;
        iv14 = 1'b0;
        din = junk();
        chk({tag, "_accepted"}, nr == 10 ? ir10 : ir14, 0);
    endtask
    task automatic wait_valid(input int nr, input string tag);
        int lat;
        lat = 0;
        while (!(nr == 10 ? ov10 : ov14) && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, nr);
    endtask
    task automatic take(input int nr, input string tag);
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sbq observed=empty expected=entry", tag);
        end else chk({tag, "_data"}, nr == 10 ? od10 : od14, sbq.pop_front());
    endtask

    initial begin
        logic seen;
        int g;
        build_sbox();
        keyexp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        keyexp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int r = 0; r <= 14; r++) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        chk("rk10_last", rk10[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv10 = 1'($urandom);
            iv14 = 1'($urandom);
            ordy = 1'($urandom);
            din = junk();
            step();
            chk("rst_in_ready", ir10, 1);
            chk("rst_out_valid", ov10, 0);
            chk("rst_out_data", od10, 0);
            chk("rst_rk_idx10", ri10, 10);
            chk("rst_rk_idx14", ri14, 14);
            chk("rst_out_valid14", ov14, 0);
        end
        rst = 1'b1;
        iv10 = 1'b0;
        iv14 = 1'b0;
        ordy = 1'b1;
        step();

        accept(10, CT10, 1, "c1");
        seen = 1'b0;
        for (int k = 9; k >= 1; k--) begin
            chk("c1_rk_idx_round", ri10, k);
            seen |= ov10;
            step();
        end
        chk("c1_rk_idx_last", ri10, 0);
        seen |= ov10;
        chk("c1_no_early_valid", seen, 0);
        step();
        chk("c1_out_valid", ov10, 1);
        chk("c1_rk_idx_done", ri10, 0);
        chk("c1_in_ready_done", ir10, 0);
        take(10, "c1");
        step();
        chk("c1_valid_drop", ov10, 0);
        chk("c1_back_idle", ir10, 1);

        accept(14, CT14, 1, "c3");
        wait_valid(14, "c3");
        take(14, "c3");
        step();
        chk("c3_valid_drop", ov14, 0);

        ordy = 1'b0;
        accept(10, CT10, 1, "stall");
        wait_valid(10, "stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", ov10, 1);
            chk("stall_data", od10, PT);
            chk("stall_in_ready", ir10, 0);
            din = junk();
            step();
        end
        ordy = 1'b1;
        take(10, "stall");
        step();
        chk("stall_valid_drop", ov10, 0);
        chk("stall_idle", ir10, 1);

        din = CT10;
        iv10 = 1'b1;
        sbq.push_back(PT);
        step();
        g = 0;
        seen = 1'b0;
        while (!ir10 && g < 30) begin
            if (ov10 && !seen) begin
                seen = 1'b1;
                chk("b2b_first_latency", g, 10);
                take(10, "b2b_first");
            end
            din = junk();
            step();
            g++;
        end
        chk("b2b_first_seen", seen, 1);
        chk("b2b_gap", g, 11);
        din = CT10;
        sbq.push_back(PT);
        step();
        iv10 = 1'b0;
        din = junk();
        chk("b2b_second_accept", ir10, 0);
        wait_valid(10, "b2b_second");
        take(10, "b2b_second");
        step();

        accept(10, CT10, 0, "abort");
        for (int i = 0; i < 4; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_in_ready", ir10, 1);
        chk("abort_out_valid", ov10, 0);
        chk("abort_rk_idx", ri10, 10);
        chk("abort_out_data", od10, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen |= ov10;
        end
        chk("abort_no_output", seen, 0);
        accept(10, CT10, 1, "fresh");
        wait_valid(10, "fresh");
        take(10, "fresh");
        step();
        chk("sbq_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative, parametrised AES inverse cipher: decrypts one 128-bit block in NR round iterations, one round per clock.
- Succeeds the fixed, combinational single decrypt round stage. Adds a configurable round count, an internal round sequencer, a round-key index request port and valid/ready handshakes on both sides.
- Sits between the ciphertext source and the plaintext sink. The key schedule lives outside this block and is read combinationally through rk_idx/rk_data.

Parameters:
- NR, 10, number of rounds. Legal values are 10/12/14 (AES-128/192/256); any other value is an elaboration error.
- RKI_W, 4, width of rk_idx. Must satisfy 2^RKI_W > NR.

Ports:
- clk, in, 1, single clock; all logic is on the rising edge.
- rst, in, 1, synchronous, active-low reset.
- in_valid, in, 1, ciphertext block valid.
- in_ready, out, 1, block can accept a ciphertext.
- in_data, in, 128, ciphertext block.
- rk_idx, out, RKI_W, index of the round key requested this cycle.
- rk_data, in, 128, round key rk[rk_idx]; combinational return, valid in the same cycle.
- out_valid, out, 1, plaintext block valid.
- out_ready, in, 1, sink accepts the plaintext.
- out_data, out, 128, plaintext block.

Behaviour:
- Byte mapping: state byte s[r][c] = bits [127-8*(r+4c) -: 8], so byte 0 is in [127:120]. This is FIPS-197 column-major order. in_data, rk_data and out_data all use this mapping.
- Reset (rst=0 at a clock edge): FSM goes to IDLE, round counter = 0, state register = 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, rk_idx=NR.
  - Reset mid-operation aborts the block. No out_valid is produced for the aborted block.
- FSM states are IDLE, ROUND, LAST, DONE.
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On in_valid: state <= in_data ^ rk_data (initial AddRoundKey), cnt <= NR-1, go to ROUND.
- ROUND:
  - in_ready=0, rk_idx=cnt.
  - state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data)).
  - If cnt==1, go to LAST; otherwise cnt <= cnt-1.
  - Occupies NR-1 cycles.
- LAST:
  - rk_idx=0.
  - state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data). No InvMixColumns.
  - Go to DONE.
- DONE:
  - out_valid=1, out_data=state, rk_idx=0, in_ready=0.
  - out_data is held stable while out_ready=0, for any number of stall cycles.
  - On out_ready=1: go to IDLE. out_valid drops on the next cycle.
- out_data is driven from the state register only. It reads 0 after reset and holds the last result otherwise; it is meaningful only while out_valid=1.
- Latency: out_valid rises exactly NR cycles after the accepting edge (10 for NR=10).
  - Minimum interval between accepts is NR+2 cycles.
  - No accept in the same cycle as the DONE handshake.
- in_data and rk_data are sampled only at the edges described above. in_valid while in_ready=0 is ignored and no data is captured.
- The inverse S-box is a 256-entry combinational table, instantiated 16 times.
- InvMixColumns uses GF(2^8) multiply by 0x0e/0x0b/0x0d/0x09, built from xtime with reduction polynomial 0x11b.
- The datapath is fully combinational between state register updates. No multicycle paths.

Test Plan:
- NR=10, FIPS-197 C.1, rk from the 000102…0f key schedule (rk[10]=13111d7fe3944a17f307a78b4d2b30c5), in_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_valid exactly 10 cycles after accept, out_data=00112233445566778899aabbccddeeff. rk_idx sequence 10,9,…,1,0.
- NR=14, FIPS-197 C.3, key 00…1f, in_data=8ea2b7ca516745bfeafc49904b496089 -> out_data=00112233445566778899aabbccddeeff after 14 cycles.
- Output stall: C.1 vector with out_ready=0 for 5 cycles after out_valid -> out_valid and out_data held stable; in_ready=0 throughout; on out_ready=1 -> IDLE next cycle.
- Back-to-back: two C.1 blocks with in_valid held high -> second accept exactly NR+2 cycles after the first; both outputs correct. in_valid during ROUND does not alter the state.
- Reset mid-block: assert rst=0 at round 5 for 1 cycle -> in_ready=1, out_valid=0, rk_idx=NR. A following fresh C.1 block decrypts correctly.
- Reset values: hold rst=0 for 3 cycles with random inputs -> in_ready=1, out_valid=0, out_data=0 throughout.
